// File: rtl/vx_perf_memsys_reader_if.sv
// Memory-system performance-counter bundle: 15 free-running counters
// published by the memory system (master) and observed by CSR readers (slave).
interface VX_perf_memsys_if #(
    parameter int PERF_CTR_BITS = 44
) ();
    logic [PERF_CTR_BITS-1:0] icache_reads;
    logic [PERF_CTR_BITS-1:0] icache_read_misses;
    logic [PERF_CTR_BITS-1:0] dcache_reads;
    logic [PERF_CTR_BITS-1:0] dcache_writes;
    logic [PERF_CTR_BITS-1:0] dcache_read_misses;
    logic [PERF_CTR_BITS-1:0] dcache_write_misses;
    logic [PERF_CTR_BITS-1:0] dcache_bank_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_mshr_stalls;
    logic [PERF_CTR_BITS-1:0] smem_reads;
    logic [PERF_CTR_BITS-1:0] smem_writes;
    logic [PERF_CTR_BITS-1:0] smem_bank_stalls;
    logic [PERF_CTR_BITS-1:0] mem_reads;
    logic [PERF_CTR_BITS-1:0] mem_writes;
    logic [PERF_CTR_BITS-1:0] mem_latency;
    logic [PERF_CTR_BITS-1:0] w_count;

    modport master (
        output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
               dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
               dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
               mem_reads, mem_writes, mem_latency, w_count
    );

    modport slave (
        input  icache_reads, icache_read_misses, dcache_reads, dcache_writes,
               dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
               dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
               mem_reads, mem_writes, mem_latency, w_count
    );
endinterface

// File: rtl/vx_perf_memsys_reader.sv
// CSR-side reader of the memsys counters: 32-bit halves through a one-slot
// valid/ready pipeline, with a LO-read snapshot so LO+HI pairs are coherent.
module vx_perf_memsys_reader #(
    parameter int          PERF_CTR_BITS = 44,
    parameter logic [11:0] CSR_LO_BASE   = 12'hB03,
    parameter logic [11:0] CSR_HI_BASE   = 12'hB83
) (
    input  logic                   clk,
    input  logic                   reset,
    VX_perf_memsys_if.slave        perf_memsys_if,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [11:0]            req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic                   rsp_hit
);
    localparam logic [0:0] SNAP_IDLE  = 1'b0;
    localparam logic [0:0] SNAP_ARMED = 1'b1;

    logic [63:0] w_ctr [16];
    logic [11:0] w_lo_off;
    logic [11:0] w_hi_off;
    logic        w_is_lo;
    logic        w_is_hi;
    logic [3:0]  w_idx;
    logic [63:0] w_sel;
    logic        w_snap_hit;
    logic [31:0] w_data;
    logic        w_accept;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_hit;
    logic [0:0]  r_snap_state;
    logic [3:0]  r_snap_idx;
    // Only the upper half of a snapshot is ever returned, so only it is kept.
    logic [31:0] r_snap_hi;

    assign w_ctr[0]  = 64'(perf_memsys_if.icache_reads);
    assign w_ctr[1]  = 64'(perf_memsys_if.icache_read_misses);
    assign w_ctr[2]  = 64'(perf_memsys_if.dcache_reads);
    assign w_ctr[3]  = 64'(perf_memsys_if.dcache_writes);
    assign w_ctr[4]  = 64'(perf_memsys_if.dcache_read_misses);
    assign w_ctr[5]  = 64'(perf_memsys_if.dcache_write_misses);
    assign w_ctr[6]  = 64'(perf_memsys_if.dcache_bank_stalls);
    assign w_ctr[7]  = 64'(perf_memsys_if.dcache_mshr_stalls);
    assign w_ctr[8]  = 64'(perf_memsys_if.smem_reads);
    assign w_ctr[9]  = 64'(perf_memsys_if.smem_writes);
    assign w_ctr[10] = 64'(perf_memsys_if.smem_bank_stalls);
    assign w_ctr[11] = 64'(perf_memsys_if.mem_reads);
    assign w_ctr[12] = 64'(perf_memsys_if.mem_writes);
    assign w_ctr[13] = 64'(perf_memsys_if.mem_latency);
    assign w_ctr[14] = 64'(perf_memsys_if.w_count);
    assign w_ctr[15] = 64'd0;

    // Unsigned wrap makes addresses below a base fall outside the 0..14 window.
    assign w_lo_off   = req_addr - CSR_LO_BASE;
    assign w_hi_off   = req_addr - CSR_HI_BASE;
    assign w_is_lo    = (w_lo_off < 12'd15);
    assign w_is_hi    = !w_is_lo && (w_hi_off < 12'd15);
    assign w_idx      = w_is_lo ? w_lo_off[3:0] : w_hi_off[3:0];
    assign w_sel      = w_ctr[w_idx];
    assign w_snap_hit = w_is_hi && (r_snap_state == SNAP_ARMED) && (r_snap_idx == w_idx);

    always_comb begin
        w_data = 32'd0;
        if (w_is_lo)
            w_data = w_sel[31:0];
        else if (w_snap_hit)
            w_data = r_snap_hi;
        else if (w_is_hi)
            w_data = w_sel[63:32];
    end

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
            r_rsp_hit    <= 1'b0;
            r_snap_state <= SNAP_IDLE;
            r_snap_idx   <= 4'd0;
            r_snap_hi    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_data;
                r_rsp_hit   <= w_is_lo || w_is_hi;
                if (w_is_lo) begin
                    r_snap_state <= SNAP_ARMED;
                    r_snap_idx   <= w_idx;
                    r_snap_hi    <= w_sel[63:32];
                end else if (w_snap_hit) begin
                    r_snap_state <= SNAP_IDLE;
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
endmodule

// File: tb/tb_vx_perf_memsys_reader.sv
// Scoreboard bench for vx_perf_memsys_reader: a behavioural snapshot model
// predicts each response at accept time; responses are checked in order.
module tb_vx_perf_memsys_reader;
    localparam logic [11:0] LO = 12'hB03;
    localparam logic [11:0] HI = 12'hB83;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = 12'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_hit;

    logic [43:0] ctr [15];

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit          m_armed = 0;
    logic [3:0]  m_idx   = 4'd0;
    logic [31:0] m_hi    = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    VX_perf_memsys_if #(.PERF_CTR_BITS(44)) perf_if ();
    assign perf_if.icache_reads        = ctr[0];
    assign perf_if.icache_read_misses  = ctr[1];
    assign perf_if.dcache_reads        = ctr[2];
    assign perf_if.dcache_writes       = ctr[3];
    assign perf_if.dcache_read_misses  = ctr[4];
    assign perf_if.dcache_write_misses = ctr[5];
    assign perf_if.dcache_bank_stalls  = ctr[6];
    assign perf_if.dcache_mshr_stalls  = ctr[7];
    assign perf_if.smem_reads          = ctr[8];
    assign perf_if.smem_writes         = ctr[9];
    assign perf_if.smem_bank_stalls    = ctr[10];
    assign perf_if.mem_reads           = ctr[11];
    assign perf_if.mem_writes          = ctr[12];
    assign perf_if.mem_latency         = ctr[13];
    assign perf_if.w_count             = ctr[14];

    vx_perf_memsys_reader #(
        .PERF_CTR_BITS(44),
        .CSR_LO_BASE  (LO),
        .CSR_HI_BASE  (HI)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .perf_memsys_if(perf_if),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_hit       (rsp_hit)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Behavioural prediction of one accepted request; updates the snapshot model.
    function automatic exp_t predict(input logic [11:0] addr);
        exp_t        e;
        logic [11:0] ol;
        logic [11:0] oh;
        logic [63:0] v;
        ol = addr - LO;
        oh = addr - HI;
        e.data = 32'd0;
        e.hit  = 1'b0;
        if (ol < 12'd15) begin
            v = {20'd0, ctr[ol]};
            e.data  = v[31:0];
            e.hit   = 1'b1;
            m_armed = 1;
            m_idx   = ol[3:0];
            m_hi    = v[63:32];
        end else if (oh < 12'd15) begin
            v = {20'd0, ctr[oh]};
            e.hit = 1'b1;
            if (m_armed && m_idx == oh[3:0]) begin
                e.data  = m_hi;
                m_armed = 0;
            end else begin
                e.data = v[63:32];
            end
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [11:0] addr, input bit use_c = 0,
                         input logic [31:0] c_data = 32'd0, input logic c_hit = 1'b1);
        bit   got;
        exp_t e;
        got = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e = predict(addr);
                if (use_c) begin
                    chk("model", {31'd0, e.hit, e.data}, {31'd0, c_hit, c_data});
                    e.data = c_data;
                    e.hit  = c_hit;
                end
                sb_q.push_back(e);
                $display("req addr=%h exp_data=%h exp_hit=%0d", addr, e.data, e.hit);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: in-order compare of consumed responses and 1-cycle latency.
    bit prev_acc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_acc = 0;
        end else begin
            if (prev_acc) chk("latency", {63'd0, rsp_valid}, 64'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp data=%h hit=%0d", rsp_data, rsp_hit);
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                    chk("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
                end
            end
            prev_acc = req_valid && req_ready;
        end
    end

    initial begin
        for (int i = 0; i < 15; i++) ctr[i] = 44'({$urandom(), $urandom()});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("reset_rsp_hit", {63'd0, rsp_hit}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);

        // Coherent LO/HI pair while the counter changes underneath.
        ctr[2] = 44'h0A_1234_5678;
        issue(12'hB05, 1, 32'h1234_5678, 1'b1);
        ctr[2] = 44'h0B_0000_0000;
        issue(12'hB85, 1, 32'h0000_000A, 1'b1);
        issue(12'hB85, 1, 32'h0000_000B, 1'b1);
        idle(2);

        // Snapshot overwrite by a LO read of another index.
        ctr[0]  = 44'h123_4567_89AB;
        ctr[14] = 44'hFED_CBA9_8765;
        issue(12'hB03);
        issue(12'hB11);
        ctr[0]  = 44'h456_0000_0000;
        ctr[14] = 44'h789_0000_0000;
        issue(12'hB83, 1, 32'h0000_0456, 1'b1);
        issue(12'hB91, 1, 32'h0000_0FED, 1'b1);
        idle(2);

        // Backpressure: held response, req_ready low, then no-bubble resume.
        rsp_ready = 1'b0;
        issue(12'hB06);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data", {32'd0, rsp_data}, {32'd0, sb_q[0].data});
            chk("bp_rsp_hit", {63'd0, rsp_hit}, {63'd0, sb_q[0].hit});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(12'hB86);
        idle(2);

        // Streaming: 15 back-to-back LO reads.
        for (int i = 0; i < 15; i++) issue(LO + 12'(i));
        idle(2);

        // Unmapped addresses leave the armed snapshot intact.
        ctr[7] = 44'hABC_0000_0001;
        issue(12'hB0A);
        ctr[7] = 44'h111_0000_0001;
        issue(12'hB20, 1, 32'd0, 1'b0);
        issue(12'hB02, 1, 32'd0, 1'b0);
        issue(12'hB8A, 1, 32'h0000_0ABC, 1'b1);
        idle(2);

        // Reset with a pending response and an armed snapshot.
        ctr[4] = 44'h222_0000_0003;
        rsp_ready = 1'b0;
        issue(12'hB07);
        req_valid = 1'b0;
        ctr[4] = 44'h333_0000_0003;
        reset = 1'b1;
        sb_q.delete();
        m_armed = 0;
        @(posedge clk);
        #1;
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_rsp_data", {32'd0, rsp_data}, 64'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        issue(12'hB87, 1, 32'h0000_0333, 1'b1);
        idle(2);

        // A few random reads, mapped and unmapped.
        for (int i = 0; i < 20; i++) begin
            ctr[$urandom_range(0, 14)] = 44'({$urandom(), $urandom()});
            issue(12'hB00 + 12'($urandom_range(0, 159)));
        end
        idle(4);

        chk("drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
